spi_rx_capture: RTL
===================

# spi_rx_capture

Read-back receiver on the SPI configuration path, downstream of the SPI master that pushes the 32-word register table to the external device. It samples the master's `spi_clk`, `spi_csn` and the device's `spi_sdo` in the 50 MHz system clock domain. It assembles 16-bit MSB-first words, presents each word with a one-cycle valid pulse and its word index, and raises sticky done and frame-error flags for the configuration checker.

## Interface
Parameters:
- `DATA_W`, default 16: bits per SPI frame; one frame carries exactly one word.
- `WORD_NUM`, default 32: number of words in one configuration pass.
- `ADDR_W`, default 5: width of `rx_addr`; satisfies 2^ADDR_W ≥ WORD_NUM.

Ports:
- `sclk`, in, 1: system clock, 50 MHz. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: arm request, sampled only in IDLE.
- `spi_clk`, in, 1: SPI clock from the master; idles low. Asynchronous to `sclk` after routing.
- `spi_csn`, in, 1: chip select, active low.
- `spi_sdo`, in, 1: serial data from the device.
- `rx_data`, out, DATA_W: last completed word.
- `rx_valid`, out, 1: one-cycle pulse marking a new `rx_data`.
- `rx_addr`, out, ADDR_W: index of the word in `rx_data`, counting from 0.
- `rx_done`, out, 1: sticky; high once WORD_NUM words have been received.
- `frame_err`, out, 1: sticky; high after any malformed frame.

## Operation
- **Input synchronisation**
  - `spi_clk`, `spi_csn` and `spi_sdo` each pass through a 2-flop synchroniser of identical depth, so data stays aligned with the clock.
  - A third register on the synchronised `spi_clk` and `spi_csn` provides edge detection: `clk_rise`, `csn_fall`, `csn_rise`.
- **IDLE**
  - `en`=1 → ARMED. Otherwise stay.
- **ARMED**
  - Wait for `csn_fall` → SHIFT, with `bit_cnt`=0.
  - A frame already in progress when ARMED is entered (csn already low) is ignored entirely.
- **SHIFT**
  - On each `clk_rise`: `shift` <= {`shift`[DATA_W-2:0], `sdo_sync`} and `bit_cnt`++.
  - On the DATA_W-th rise, in the same cycle:
    - `rx_data` <= completed word.
    - `rx_valid` <= 1.
    - `rx_addr` <= `word_cnt`.
    - `word_cnt`++.
    - Go to HOLD.
  - `csn_rise` before DATA_W bits: set `frame_err`, discard partial bits, do not change `word_cnt`, go to ARMED.
- **HOLD**
  - Any `clk_rise`: set `frame_err` and ignore the bit.
  - `csn_rise`: go to DONE if `word_cnt`==WORD_NUM, else ARMED.
- **DONE**
  - `rx_done`=1. All further SPI activity is ignored until `rst`.
- **Simultaneous events**
  - A `clk_rise` detected in the same cycle as `csn_fall` is ignored. Counting starts in SHIFT.
  - `clk_rise` and `csn_rise` in the same SHIFT cycle: the bit is taken first, then the csn rule applies. If that bit completes the word, the word is valid and the block goes straight to ARMED or DONE.
- **`en` and abort**
  - `en` is ignored outside IDLE; deasserting it has no effect. `rst` is the only abort.
- **Counters**
  - `word_cnt` is ADDR_W+1 bits wide and never wraps; DONE stops it.
  - `bit_cnt` is ceil(log2(DATA_W))+1 bits wide.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `rx_addr`=0, `rx_done`=0, `frame_err`=0. Reset also clears the state (to IDLE), all counters, the shift register and the synchronisers (sync flops reset to the idle levels: clk 0, csn 1).
- **Reset mid-frame:** the partial word is lost. After rearm, the rest of that frame is ignored per the ARMED rule.
- **Latency:**
  - `rx_valid` is high during the cycle following the 3rd `sclk` rising edge after the DATA_W-th `spi_clk` rising edge reaches the pin.
  - `rx_data` and `rx_addr` change only in that cycle and then hold until the next word.
- **`rx_valid` pulses:** exactly 1 cycle wide, at most one per frame.
- **`rx_done` and `frame_err`:**
  - `rx_done` rises 3 cycles after the final frame's csn rise at the pin.
  - Once set, `rx_done` and `frame_err` stay high until `rst`.
- **Input constraint:** `spi_clk` high and low phases must each be ≥ 3 `sclk` cycles. The nominal 1 MHz SPI clock gives 25.
- **`sdo` sampling:** `sdo` must be stable from 1 `sclk` cycle before to 1 cycle after the `spi_clk` rising edge at the pin.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `spi_csn` low and `spi_clk` toggling → all outputs are 0, no `rx_valid`, and the state is IDLE.
- **Single word:** pulse `en`, then send one frame 16'hA5C3 → one `rx_valid` with `rx_data`=16'hA5C3 and `rx_addr`=0, 3 cycles after the 16th edge; `frame_err`=0.
- **Full pass:** send 32 frames with data = i*16'h0101 → `rx_addr` runs 0..31 with matching data. `rx_done`=1 after frame 31's csn rise. A 33rd frame produces no `rx_valid`.
- **Short frame:** 9 clocks, then csn high → `frame_err`=1 and no `rx_valid`. The next full frame 16'h1234 is reported with the unchanged `rx_addr`.
- **Long frame:** 17 clocks in one frame → the word formed from the first 16 bits is valid and `frame_err`=1.
- **Arm mid-frame:** pulse `en` while csn is already low mid-frame → that frame is ignored entirely. The following frame 16'hFFFF is captured at `rx_addr`=0.

Source files
------------

// File: rtl/spi_rx_capture.sv
// SPI read-back receiver: samples the SPI master's clock, chip select and the device's sdo in the sclk domain,
// assembles MSB-first words and reports each word with its index, plus sticky done and frame-error flags.
module spi_rx_capture #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WORD_NUM = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              en,
  input  logic              spi_clk,
  input  logic              spi_csn,
  input  logic              spi_sdo,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              rx_done,
  output logic              frame_err
);

  localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [2:0]        clk_sync, csn_sync;
  logic [1:0]        sdo_sync;
  logic [2:0]        prime;
  logic [DATA_W-1:0] shift, shift_n, shifted;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]  word_cnt, word_cnt_n;
  logic [DATA_W-1:0] rx_data_n;
  logic [ADDR_W-1:0] rx_addr_n;
  logic              rx_valid_n, rx_done_n, frame_err_n;
  logic              clk_rise, csn_fall, csn_rise;

  // Equal-depth synchronisers; the third stage on clk/csn feeds the edge detectors
  always_ff @(posedge sclk) begin
    if (rst) begin
      clk_sync <= 3'b000;
      csn_sync <= 3'b111;
      sdo_sync <= 2'b00;
      prime    <= 3'b000;
    end else begin
      clk_sync <= {clk_sync[1:0], spi_clk};
      csn_sync <= {csn_sync[1:0], spi_csn};
      sdo_sync <= {sdo_sync[0], spi_sdo};
      prime    <= {prime[1:0], 1'b1};
    end
  end

  // Edges are masked until the chain holds real pin levels, so a csn already low
  // at reset release never looks like a fresh frame start.
  assign clk_rise = prime[2] &  clk_sync[1] & ~clk_sync[2];
  assign csn_fall = prime[2] & ~csn_sync[1] &  csn_sync[2];
  assign csn_rise = prime[2] &  csn_sync[1] & ~csn_sync[2];

  assign shifted = {shift[DATA_W-2:0], sdo_sync[1]};

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= S_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_addr   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      word_cnt  <= word_cnt_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_addr   <= rx_addr_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    bit_cnt_n   = bit_cnt;
    word_cnt_n  = word_cnt;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    rx_addr_n   = rx_addr;
    frame_err_n = frame_err;

    case (state)
      S_IDLE: begin
        if (en) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (csn_fall) begin
          state_n   = S_SHIFT;
          bit_cnt_n = '0;
          shift_n   = '0;
        end
      end
      S_SHIFT: begin
        // A bit arriving with csn_rise is taken before the frame-end check
        if (clk_rise) begin
          shift_n   = shifted;
          bit_cnt_n = BIT_W'(bit_cnt + 1'b1);
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            rx_data_n  = shifted;
            rx_valid_n = 1'b1;
            rx_addr_n  = word_cnt[ADDR_W-1:0];
            word_cnt_n = CNT_W'(word_cnt + 1'b1);
            if (csn_rise)
              state_n = (word_cnt_n == CNT_W'(WORD_NUM)) ? S_DONE : S_ARMED;
            else
              state_n = S_HOLD;
          end else if (csn_rise) begin
            frame_err_n = 1'b1;
            state_n     = S_ARMED;
          end
        end else if (csn_rise) begin
          frame_err_n = 1'b1;
          state_n     = S_ARMED;
        end
      end
      S_HOLD: begin
        if (clk_rise) frame_err_n = 1'b1;
        if (csn_rise)
          state_n = (word_cnt == CNT_W'(WORD_NUM)) ? S_DONE : S_ARMED;
      end
      S_DONE: begin
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase

    rx_done_n = rx_done | (state_n == S_DONE);
  end

endmodule
